// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed 7-segment scan controller.
// Digits are shown from shadow registers that only change at a frame boundary,
// so a new value from the lock FSM never tears mid-frame. Brightness is a
// per-slot duty limit; a short guard at each slot start blanks the anodes to
// suppress ghosting while the segment bus changes.
module seg_scan_ctrl #(
    parameter int REFRESH_W = 17,
    parameter int GUARD     = 64,
    parameter int BLINK_W   = 7
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blink_mask,
    input  logic [2:0]  brightness,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    localparam logic [REFRESH_W-1:0] CNT_ZERO = {REFRESH_W{1'b0}};
    localparam logic [REFRESH_W-1:0] CNT_ONE  = {{(REFRESH_W-1){1'b0}}, 1'b1};
    localparam logic [REFRESH_W-1:0] CNT_MAX  = {REFRESH_W{1'b1}};
    localparam logic [REFRESH_W-1:0] GUARD_C  = REFRESH_W'(GUARD);
    localparam logic [BLINK_W-1:0]   FRM_ZERO = {BLINK_W{1'b0}};
    localparam logic [BLINK_W-1:0]   FRM_ONE  = {{(BLINK_W-1){1'b0}}, 1'b1};

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [REFRESH_W-1:0] cnt_r;
    logic [1:0]           idx_r;
    logic [BLINK_W-1:0]   frame_cnt_r;
    logic [2:0]           bright_r;
    logic [15:0]          digits_r;
    logic [3:0]           en_r;
    logic [3:0]           dp_r;
    logic [3:0]           blink_r;
    logic                 upd_ack_r;
    logic [3:0]           an_r;
    logic [6:0]           seg_r;
    logic                 dp_n_r;

    logic       tick_s;
    logic       frame_end_s;
    logic       blink_ph_s;
    logic [2:0] phase_s;
    logic [3:0] nib_s;
    logic       on_s;

    assign tick_s      = (cnt_r == CNT_MAX);
    assign frame_end_s = tick_s && (idx_r == 2'd3);
    assign blink_ph_s  = frame_cnt_r[BLINK_W-1];
    assign phase_s     = cnt_r[REFRESH_W-1 -: 3];

    // Pick the shadow nibble belonging to the digit slot being scanned.
    always_comb begin
        nib_s = 4'h0;
        case (idx_r)
            2'd0:    nib_s = digits_r[3:0];
            2'd1:    nib_s = digits_r[7:4];
            2'd2:    nib_s = digits_r[11:8];
            2'd3:    nib_s = digits_r[15:12];
            default: nib_s = 4'h0;
        endcase
    end

    // Light the current digit outside the guard, within the duty window, when enabled and not in the blink-off phase.
    always_comb begin
        on_s = 1'b0;
        if ((cnt_r >= GUARD_C) && (phase_s <= bright_r) && en_r[idx_r] &&
            !(blink_r[idx_r] && blink_ph_s)) begin
            on_s = 1'b1;
        end else begin
            on_s = 1'b0;
        end
    end

    // Slot timer, digit index, frame counter and slot-boundary brightness sampling.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_r       <= CNT_ZERO;
            idx_r       <= 2'd0;
            frame_cnt_r <= FRM_ZERO;
            bright_r    <= 3'd0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (tick_s) begin
                idx_r    <= idx_r + 2'd1;
                bright_r <= brightness;
            end
            if (frame_end_s) begin
                frame_cnt_r <= frame_cnt_r + FRM_ONE;
            end
        end
    end

    // Frame-synchronous shadow load with a single-cycle acknowledge.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            digits_r  <= 16'h0000;
            en_r      <= 4'b0000;
            dp_r      <= 4'b0000;
            blink_r   <= 4'b0000;
            upd_ack_r <= 1'b0;
        end else begin
            if (frame_end_s && upd_req) begin
                digits_r <= digits;
                en_r     <= digit_en;
                dp_r     <= dp_in;
                blink_r  <= blink_mask;
            end
            upd_ack_r <= frame_end_s && upd_req;
        end
    end

    // Registered display drive; only one anode can be selected at a time.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            an_r   <= 4'b1111;
            seg_r  <= 7'b1111111;
            dp_n_r <= 1'b1;
        end else begin
            if (on_s) begin
                an_r  <= ~(4'b0001 << idx_r);
                seg_r <= hex_to_seg(nib_s);
            end else begin
                an_r  <= 4'b1111;
                seg_r <= 7'b1111111;
            end
            dp_n_r <= !(on_s && dp_r[idx_r]);
        end
    end

    assign upd_ack = upd_ack_r;
    assign an      = an_r;
    assign seg     = seg_r;
    assign dp_n    = dp_n_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 32-clock slot (128-clock frame).
// Windows of 128 samples start right after an upd_ack cycle, so sample j
// reflects slot counter value j-1 of the frame that follows.
module tb_seg_scan_ctrl;

    logic        clk_in;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [2:0]  brightness;
    logic        upd_req;
    logic        upd_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    int n_tests;
    int n_fail;

    int         lit_cnt[4];
    int         first_j[4];
    int         last_j[4];
    logic [6:0] seg_last[4];
    int         dp_lo;
    int         dp_bad;
    int         multi;
    int         ack_j;
    int         ack_n;
    int         cyc;
    int         blink_lit[8];
    int         exp_bl[8];

    seg_scan_ctrl #(
        .REFRESH_W(5),
        .GUARD    (1),
        .BLINK_W  (2)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .digits    (digits),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
        .blink_mask(blink_mask),
        .brightness(brightness),
        .upd_req   (upd_req),
        .upd_ack   (upd_ack),
        .an        (an),
        .seg       (seg),
        .dp_n      (dp_n)
    );

    // Free-running 100 MHz-style clock.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for an upd_ack pulse; cyc returns negedges waited (300 on timeout).
    task automatic wait_ack(output int cyc_o);
        bit found;
        found = 1'b0;
        cyc_o = 0;
        while (!found && cyc_o < 300) begin
            @(negedge clk_in);
            cyc_o++;
            if (upd_ack) found = 1'b1;
        end
    endtask

    // Observe one 128-clock window, optionally raising a request or changing brightness at a given sample.
    task automatic measure_frame(input int req_j, input logic [15:0] req_dig,
                                 input int br_j, input logic [2:0] br_val);
        int nlow;
        for (int a = 0; a < 4; a++) begin
            lit_cnt[a]  = 0;
            first_j[a]  = 0;
            last_j[a]   = 0;
            seg_last[a] = 7'b1111111;
        end
        dp_lo = 0; dp_bad = 0; multi = 0; ack_j = 0; ack_n = 0;
        for (int j = 1; j <= 128; j++) begin
            @(negedge clk_in);
            nlow = 0;
            for (int a = 0; a < 4; a++) begin
                if (an[a] == 1'b0) begin
                    nlow++;
                    lit_cnt[a]++;
                    if (first_j[a] == 0) first_j[a] = j;
                    last_j[a]   = j;
                    seg_last[a] = seg;
                end
            end
            if (nlow > 1) multi++;
            if (dp_n == 1'b0) begin
                dp_lo++;
                if (an != 4'b1011) dp_bad++;
            end
            if (upd_ack) begin
                ack_n++;
                if (ack_j == 0) ack_j = j;
                upd_req = 1'b0;
            end
            if (j == req_j) begin
                digits  = req_dig;
                upd_req = 1'b1;
            end
            if (j == br_j) brightness = br_val;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_bl  = '{0, 31, 31, 0, 0, 31, 31, 0};
        reset      = 1'b0;
        digits     = 16'h0000;
        digit_en   = 4'b0000;
        dp_in      = 4'b0000;
        blink_mask = 4'b0000;
        brightness = 3'd7;
        upd_req    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_in);
        check_eq("rst_an",  32'(an),      32'(4'b1111));
        check_eq("rst_seg", 32'(seg),     32'(7'b1111111));
        check_eq("rst_dp",  32'(dp_n),    32'(1'b1));
        check_eq("rst_ack", 32'(upd_ack), 32'(1'b0));

        // First load of 1234, acknowledged at the end of frame 0
        reset    = 1'b1;
        digits   = 16'h1234;
        digit_en = 4'b1111;
        upd_req  = 1'b1;
        wait_ack(cyc);
        check_eq("load_ack_lat", 32'(cyc), 32'd128);
        upd_req = 1'b0;

        // Full-brightness scan of 1234
        measure_frame(0, 16'h0000, 0, 3'd0);
        for (int a = 0; a < 4; a++) check_eq($sformatf("t1_lit%0d", a), 32'(lit_cnt[a]), 32'd31);
        check_eq("t1_first0", 32'(first_j[0]), 32'd2);
        check_eq("t1_last0",  32'(last_j[0]),  32'd32);
        check_eq("t1_first3", 32'(first_j[3]), 32'd98);
        check_eq("t1_last3",  32'(last_j[3]),  32'd128);
        check_eq("t1_seg0",   32'(seg_last[0]), 32'(7'b0011001));
        check_eq("t1_seg1",   32'(seg_last[1]), 32'(7'b0110000));
        check_eq("t1_seg2",   32'(seg_last[2]), 32'(7'b0100100));
        check_eq("t1_seg3",   32'(seg_last[3]), 32'(7'b1111001));
        check_eq("t1_multi",  32'(multi), 32'd0);
        check_eq("t1_dp",     32'(dp_lo), 32'd0);
        check_eq("t1_noack",  32'(ack_n), 32'd0);

        // Mid-frame request for 00A0: current frame unchanged, ack right after frame end
        measure_frame(40, 16'h00A0, 0, 3'd0);
        check_eq("t2_seg1_old", 32'(seg_last[1]), 32'(7'b0110000));
        check_eq("t2_ack_j",    32'(ack_j), 32'd128);
        check_eq("t2_ack_n",    32'(ack_n), 32'd1);

        // New frame shows 00A0; brightness drops to 0 late in slot 3
        measure_frame(0, 16'h0000, 120, 3'd0);
        check_eq("t2_seg0", 32'(seg_last[0]), 32'(7'b1000000));
        check_eq("t2_seg1", 32'(seg_last[1]), 32'(7'b0001000));
        check_eq("t2_seg3", 32'(seg_last[3]), 32'(7'b1000000));
        check_eq("t2_lit3", 32'(lit_cnt[3]), 32'd31);

        // Minimum brightness: cnt 1..3 only
        measure_frame(0, 16'h0000, 0, 3'd0);
        for (int a = 0; a < 4; a++) check_eq($sformatf("t3_lit%0d", a), 32'(lit_cnt[a]), 32'd3);
        check_eq("t3_first0", 32'(first_j[0]), 32'd2);
        check_eq("t3_last0",  32'(last_j[0]),  32'd4);

        // Brightness back to 7 mid-slot 0: applies from slot 1
        measure_frame(0, 16'h0000, 10, 3'd7);
        check_eq("t3_chg_lit0", 32'(lit_cnt[0]), 32'd3);
        check_eq("t3_chg_lit1", 32'(lit_cnt[1]), 32'd31);
        check_eq("t3_chg_lit3", 32'(lit_cnt[3]), 32'd31);

        // Blink digit 0: dark while frame counter is 2 or 3
        blink_mask = 4'b0001;
        upd_req    = 1'b1;
        wait_ack(cyc);
        check_eq("t4_blink_ack", 32'(cyc), 32'd128);
        upd_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            measure_frame(0, 16'h0000, 0, 3'd0);
            blink_lit[k] = lit_cnt[0];
            if (k == 0) check_eq("t4_lit1", 32'(lit_cnt[1]), 32'd31);
        end
        for (int k = 0; k < 8; k++) check_eq($sformatf("t4_blink%0d", k), 32'(blink_lit[k]), 32'(exp_bl[k]));

        // Enable mask 0101: digits 1 and 3 stay dark
        blink_mask = 4'b0000;
        digit_en   = 4'b0101;
        upd_req    = 1'b1;
        wait_ack(cyc);
        check_eq("t4_en_ack", 32'(cyc), 32'd128);
        upd_req = 1'b0;
        measure_frame(0, 16'h0000, 0, 3'd0);
        check_eq("t4_en_lit0", 32'(lit_cnt[0]), 32'd31);
        check_eq("t4_en_lit1", 32'(lit_cnt[1]), 32'd0);
        check_eq("t4_en_lit2", 32'(lit_cnt[2]), 32'd31);
        check_eq("t4_en_lit3", 32'(lit_cnt[3]), 32'd0);

        // Decimal point on digit 2 only, never during its guard clock
        digit_en = 4'b1111;
        dp_in    = 4'b0100;
        upd_req  = 1'b1;
        wait_ack(cyc);
        check_eq("t5_dp_ack", 32'(cyc), 32'd128);
        upd_req = 1'b0;
        measure_frame(0, 16'h0000, 0, 3'd0);
        check_eq("t5_dp_lo",  32'(dp_lo),  32'd31);
        check_eq("t5_dp_bad", 32'(dp_bad), 32'd0);
        check_eq("t5_multi",  32'(multi),  32'd0);

        // Held request: one ack per frame, 128 clocks apart
        upd_req = 1'b1;
        wait_ack(cyc);
        check_eq("t6_ack_a", 32'(cyc), 32'd128);
        @(negedge clk_in);
        check_eq("t6_ack_width", 32'(upd_ack), 32'(1'b0));
        wait_ack(cyc);
        check_eq("t6_ack_b", 32'(cyc), 32'd127);
        wait_ack(cyc);
        check_eq("t6_ack_c", 32'(cyc), 32'd128);

        // Reset in the middle of slot 1 blanks the outputs at once
        repeat (40) @(negedge clk_in);
        check_eq("t7_pre_an", 32'(an), 32'(4'b1101));
        #2;
        reset = 1'b0;
        #1;
        check_eq("t7_an",  32'(an),      32'(4'b1111));
        check_eq("t7_seg", 32'(seg),     32'(7'b1111111));
        check_eq("t7_dp",  32'(dp_n),    32'(1'b1));
        check_eq("t7_ack", 32'(upd_ack), 32'(1'b0));
        upd_req = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        measure_frame(0, 16'h0000, 0, 3'd0);
        check_eq("t7_dark", 32'(lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3]), 32'd0);
        check_eq("t7_noack", 32'(ack_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
